// File: rtl/pa_core_ibuf_pkg.sv
// pa_core_ibuf_pkg
//   Shared defaults for the instruction fetch buffer (PC width, instruction
//   width, buffer depth) and the push/pop operation encoding used by the
//   occupancy update logic.
package pa_core_ibuf_pkg;

   localparam int unsigned IBUF_DEPTH_DEF = 4;
   localparam int unsigned PC_W_DEF       = 32;
   localparam int unsigned INSTR_W_DEF    = 32;

   // Encoding is {pop, push} so the handshake bits map directly onto it.
   typedef enum logic [1:0] {
      IBUF_OP_IDLE = 2'b00,
      IBUF_OP_PUSH = 2'b01,
      IBUF_OP_POP  = 2'b10,
      IBUF_OP_BOTH = 2'b11
   } ibuf_op_e;

   function automatic ibuf_op_e ibuf_op(input logic push, input logic pop);
      return ibuf_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/pa_core_ibuf_mem.sv
// pa_core_ibuf_mem
//   DEPTH x WIDTH register array, one synchronous write port and one
//   asynchronous read port. Contents are not reset.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
module pa_core_ibuf_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 65
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pa_core_ibuf.sv
// pa_core_ibuf
//   Instruction fetch buffer between the IFU and decode. Queues up to DEPTH
//   {pc, instr, err} packets in a circular buffer and presents the oldest one
//   to decode. Flush (or reset) discards every queued entry.
// Ports:
//   clk_i, rst_i                core clock, synchronous active-high reset
//   flush_i                     pipeline redirect, drops all entries
//   in_valid_i / in_ready_o     IFU-side handshake
//   in_pc_i, in_instr_i, in_err_i   incoming packet
//   out_valid_o / out_ready_i   decode-side handshake
//   out_pc_o, out_instr_o, out_err_o  head packet (zero while empty)
//   count_o                     registered occupancy
module pa_core_ibuf
   import pa_core_ibuf_pkg::*;
#(
   parameter int unsigned DEPTH   = IBUF_DEPTH_DEF,
   parameter int unsigned PC_W    = PC_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [PC_W-1:0]          in_pc_i,
   input  logic [INSTR_W-1:0]       in_instr_i,
   input  logic                     in_err_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [PC_W-1:0]          out_pc_o,
   output logic [INSTR_W-1:0]       out_instr_o,
   output logic                     out_err_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = PC_W + INSTR_W + 1;

   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   ibuf_op_e      w_op;
   logic [CW-1:0] w_count_nxt;
   logic [AW-1:0] w_rd_nxt;
   logic [AW-1:0] w_wr_nxt;
   logic [EW-1:0] w_wdata;
   logic [EW-1:0] w_rdata;

   // Ready/valid come from registered occupancy only: a pop while full does
   // not open the input until the next cycle.
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign in_ready_o  = ~w_full;
   assign out_valid_o = ~w_empty;
   assign w_push      = in_valid_i & ~w_full;
   assign w_pop       = out_ready_i & ~w_empty;
   assign w_op        = ibuf_op(w_push, w_pop);

   always_comb begin
      w_count_nxt = r_count;
      w_rd_nxt    = r_rd_ptr;
      w_wr_nxt    = r_wr_ptr;
      case (w_op)
         IBUF_OP_PUSH: begin
            w_count_nxt = r_count + CW'(1);
            w_wr_nxt    = r_wr_ptr + AW'(1);
         end
         IBUF_OP_POP: begin
            w_count_nxt = r_count - CW'(1);
            w_rd_nxt    = r_rd_ptr + AW'(1);
         end
         IBUF_OP_BOTH: begin
            w_rd_nxt    = r_rd_ptr + AW'(1);
            w_wr_nxt    = r_wr_ptr + AW'(1);
         end
         default: ;
      endcase
   end

   // Flush collapses the buffer onto the write pointer; reset also zeroes it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= w_rd_nxt;
         r_wr_ptr <= w_wr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   assign w_wdata = {in_pc_i, in_instr_i, in_err_i};

   pa_core_ibuf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_mem (
      .i_clk   (clk_i),
      .i_we    (w_push & ~flush_i & ~rst_i),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // Stale storage is masked so the head fields read zero while empty.
   assign out_pc_o    = w_empty ? '0 : w_rdata[EW-1 -: PC_W];
   assign out_instr_o = w_empty ? '0 : w_rdata[INSTR_W:1];
   assign out_err_o   = w_empty ? 1'b0 : w_rdata[0];
   assign count_o     = r_count;

endmodule

// File: tb/tb_pa_core_ibuf.sv
// tb_pa_core_ibuf
//   Self-checking bench for pa_core_ibuf: a queue scoreboard receives every
//   accepted packet and is compared against the head outputs each cycle.
module tb_pa_core_ibuf;

   localparam int unsigned DEPTH = 4;

   logic        clk_i;
   logic        rst_i;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_pc_i;
   logic [31:0] in_instr_i;
   logic        in_err_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_pc_o;
   logic [31:0] out_instr_o;
   logic        out_err_o;
   logic [2:0]  count_o;

   pa_core_ibuf #(
      .DEPTH   (DEPTH),
      .PC_W    (32),
      .INSTR_W (32)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_pc_i     (in_pc_i),
      .in_instr_i  (in_instr_i),
      .in_err_i    (in_err_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_pc_o    (out_pc_o),
      .out_instr_o (out_instr_o),
      .out_err_o   (out_err_o),
      .count_o     (count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } pkt_t;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        e;
      logic        ordy;
      logic [2:0]  exp_count;
   } vec_t;

   pkt_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0013;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check current outputs against the model,
   // clock, then advance the model. Called at posedge+1.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic e, input logic ordy, input logic fl, input logic rs);
      logic m_ready;
      logic m_valid;
      logic push;
      logic pop;
      pkt_t p;
      in_valid_i  = v;
      in_pc_i     = pc;
      in_instr_i  = ins;
      in_err_i    = e;
      out_ready_i = ordy;
      flush_i     = fl;
      rst_i       = rs;
      #1;
      m_ready = (sb.size() != DEPTH);
      m_valid = (sb.size() != 0);
      chk("count", 64'(count_o), 64'(sb.size()));
      chk("in_ready", 64'(in_ready_o), 64'(m_ready));
      chk("out_valid", 64'(out_valid_o), 64'(m_valid));
      if (m_valid) begin
         chk("head_pc", 64'(out_pc_o), 64'(sb[0].pc));
         chk("head_instr", 64'(out_instr_o), 64'(sb[0].instr));
         chk("head_err", 64'(out_err_o), 64'(sb[0].err));
      end else begin
         chk("empty_pc", 64'(out_pc_o), 64'd0);
         chk("empty_instr", 64'(out_instr_o), 64'd0);
         chk("empty_err", 64'(out_err_o), 64'd0);
      end
      push = v & m_ready;
      pop  = m_valid & ordy;
      @(posedge clk_i);
      #1;
      if (rs || fl) begin
         sb.delete();
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) begin
            p.pc    = pc;
            p.instr = ins;
            p.err   = e;
            sb.push_back(p);
         end
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, ordy, 1'b0, 1'b0);
   endtask

   task automatic push_pc(input logic [31:0] pc, input logic e, input logic ordy);
      cycle(1'b1, pc, mk_instr(pc), e, ordy, 1'b0, 1'b0);
   endtask

   vec_t tbl[10];

   initial begin
      // Fill/drain table: exp_count is occupancy seen while the vector is applied.
      tbl[0] = '{1'b1, 32'h0,  1'b0, 1'b0, 3'd0};
      tbl[1] = '{1'b1, 32'h4,  1'b0, 1'b0, 3'd1};
      tbl[2] = '{1'b1, 32'h8,  1'b0, 1'b0, 3'd2};
      tbl[3] = '{1'b1, 32'hC,  1'b0, 1'b0, 3'd3};
      tbl[4] = '{1'b1, 32'h10, 1'b0, 1'b0, 3'd4};
      tbl[5] = '{1'b1, 32'h10, 1'b0, 1'b1, 3'd4};
      tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd3};
      tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd2};
      tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd1};
      tbl[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 3'd0};

      rst_i       = 1'b1;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_pc_i     = '0;
      in_instr_i  = '0;
      in_err_i    = 1'b0;
      out_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Reset state, pop request while empty is ignored.
      idle(1'b1);

      // Single push with decode ready.
      cycle(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("single_valid", 64'(out_valid_o), 64'd1);
      chk("single_pc", 64'(out_pc_o), 64'h8000_0000);
      idle(1'b1);
      chk("single_drained", 64'(count_o), 64'd0);

      // Fill until full, hold a 5th packet, then drain in order.
      for (int i = 0; i < 10; i++) begin
         #0;
         chk("tbl_count", 64'(count_o), 64'(tbl[i].exp_count));
         cycle(tbl[i].v, tbl[i].pc, mk_instr(tbl[i].pc), tbl[i].e, tbl[i].ordy, 1'b0, 1'b0);
      end

      // Streaming past pointer wrap.
      for (int i = 0; i < 20; i++) begin
         push_pc(32'h1000 + 32'(i) * 4, 1'b0, 1'b1);
      end
      chk("stream_count", 64'(count_o), 64'd1);
      idle(1'b1);
      idle(1'b0);

      // Flush with three queued entries while 0x100 is offered.
      push_pc(32'h20, 1'b0, 1'b0);
      push_pc(32'h24, 1'b0, 1'b0);
      push_pc(32'h28, 1'b0, 1'b0);
      cycle(1'b1, 32'h100, mk_instr(32'h100), 1'b0, 1'b1, 1'b1, 1'b0);
      chk("flush_count", 64'(count_o), 64'd0);
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      push_pc(32'h200, 1'b0, 1'b0);
      chk("post_flush_pc", 64'(out_pc_o), 64'h200);
      idle(1'b1);
      idle(1'b0);

      // Error flag travels only with its own entry.
      push_pc(32'h3C, 1'b0, 1'b0);
      push_pc(32'h40, 1'b1, 1'b0);
      push_pc(32'h44, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      chk("err_head", 64'(out_err_o), 64'd1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // Mid-operation reset while full and stalled.
      for (int i = 0; i < 4; i++) push_pc(32'h300 + 32'(i) * 4, 1'b0, 1'b0);
      cycle(1'b1, 32'h400, mk_instr(32'h400), 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_ready", 64'(in_ready_o), 64'd1);
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      push_pc(32'h500, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
